divide_seq_frac: RTL and testbench
==================================

DIVIDE_SEQ_FRAC -- requirements
Module: divide_seq_frac

Interface
REQ-001 Parameter WIDTH, default 8: bit width of dividend, divisor, integer quotient and remainder; legal range 4..32.
REQ-002 Parameter FRAC, default 8: number of binary fractional quotient bits; legal range 0..16.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; operands sampled when start=1 in IDLE.
REQ-006 dividend  input  WIDTH  unsigned dividend.
REQ-007 divisor  input  WIDTH  unsigned divisor.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 quotient  output  WIDTH  integer quotient, truncated.
REQ-011 fraction  output  FRAC  fractional quotient bits, MSB = 2^-1, truncated (no rounding).
REQ-012 remainder  output  WIDTH  integer remainder (dividend mod divisor).
REQ-013 div_by_zero  output  1  set when the last accepted operation had divisor = 0.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ITER, DONE.
REQ-015 IDLE: on start=1 and divisor!=0, operands SHALL be registered, partial remainder cleared, bit counter cleared, next state ITER.
REQ-016 IDLE: on start=1 and divisor=0, next state SHALL be DONE with quotient and fraction all ones, remainder=dividend, div_by_zero=1.
REQ-017 ITER SHALL produce exactly one quotient bit per clock (restoring shift-subtract), WIDTH integer bits MSB first, then FRAC fraction bits.
REQ-018 Partial remainder register SHALL be WIDTH+1 bits so the shifted value never overflows.
REQ-019 Fraction bits SHALL be generated by shifting zero into the partial remainder.
REQ-020 Integer remainder SHALL be captured after the last integer bit, before fraction iterations.
REQ-021 ITER SHALL last exactly WIDTH+FRAC cycles, then go to DONE; with FRAC=0, ITER lasts WIDTH cycles.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-023 Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH+FRAC (nonzero divisor) or after edge 0 (zero divisor).
REQ-024 busy SHALL be 1 in ITER and DONE, 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored; no queueing.
REQ-026 start in the DONE cycle SHALL be ignored; a new operation may be accepted from the following IDLE cycle (back-to-back period WIDTH+FRAC+2 cycles).
REQ-027 quotient, fraction, remainder, div_by_zero SHALL update only at the transition into DONE and hold until the next accepted operation reaches DONE.
REQ-028 div_by_zero SHALL clear when a later operation with nonzero divisor completes.
REQ-029 Operand inputs SHALL be don't-care except in the accepting IDLE cycle.

Reset
REQ-030 reset_n=0 SHALL force IDLE immediately, regardless of clock, and abort any operation in progress.
REQ-031 Reset values: busy=0, done=0, quotient=0, fraction=0, remainder=0, div_by_zero=0, internal counter and partial remainder=0.
REQ-032 After reset_n rises, the first start sampled in IDLE SHALL begin a normal operation.

Verification
REQ-033 Defaults, 7/2 -> 16 cycles later done=1 for 1 cycle; quotient=0x03, fraction=0x80, remainder=0x01, div_by_zero=0.
REQ-034 Defaults, 1/3 -> quotient=0x00, fraction=0x55, remainder=0x01; then 0xFF/0x01 back-to-back -> quotient=0xFF, fraction=0x00, remainder=0x00.
REQ-035 Defaults, 5/0 -> done in the cycle after the start edge; quotient=0xFF, fraction=0xFF, remainder=0x05, div_by_zero=1; next 8/4 -> quotient=0x02, div_by_zero=0.
REQ-036 Defaults, start 200/9, second start pulse at cycle 5 with 10/2 -> second start ignored; result quotient=0x16, fraction=0x38, remainder=0x02.
REQ-037 Defaults, start 100/7, reset_n low at cycle 6 -> busy=0 and all outputs 0 asynchronously, no done pulse; after release 100/7 -> quotient=0x0E, fraction=0x49, remainder=0x02.
REQ-038 WIDTH=16, FRAC=4, 1000/7 -> 20 cycles to done; quotient=142, fraction=0xD, remainder=6.

Source files
------------

// File: rtl/divide_seq_frac_if.sv
// Operand/result bundle for the sequential fractional divider.
// The requester side drives start and operands; the divider drives status and results.
interface divide_seq_frac_if #(
   parameter int WIDTH = 8,
   parameter int FRAC  = 8
);
   // A zero-bit vector is not legal, so the fraction port keeps a minimum width of one bit when FRAC = 0.
   localparam int FW = (FRAC > 0) ? FRAC : 1;

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [FW-1:0]    fraction;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, fraction, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, fraction, remainder, div_by_zero
   );
endinterface

// File: rtl/divide_seq_frac.sv
// Restoring shift-subtract divider: one quotient bit per clock.
// It produces WIDTH integer bits and then FRAC fraction bits, with the integer remainder kept aside.
module divide_seq_frac #(
   parameter int WIDTH = 8,
   parameter int FRAC  = 8
) (
   input  logic            Clk,
   input  logic            reset_n,
   divide_seq_frac_if.slave bus
);
   localparam int QW = WIDTH + FRAC;
   localparam int FW = (FRAC > 0) ? FRAC : 1;
   localparam int CW = $clog2(QW + 1);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] dvdShift_q;
   logic [WIDTH:0]   prem_q;
   logic [WIDTH-1:0] intRem_q;
   logic [QW-1:0]    quotBits_q;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [FW-1:0]    fraction_q;
   logic [WIDTH-1:0] remainder_q;
   logic             divByZero_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             qBit;
   logic [WIDTH:0]   prem_d;
   logic [QW-1:0]    quotBits_d;
   logic [FW-1:0]    fracBits;

   // Once the dividend has been shifted out its register is all zeros,
   // so the fraction phase shifts zeros into the partial remainder.
   always_comb begin
      shifted    = (prem_q << 1) | (WIDTH+1)'(dvdShift_q[WIDTH-1]);
      trial      = shifted - {1'b0, divisor_q};
      qBit       = (shifted >= {1'b0, divisor_q});
      prem_d     = qBit ? trial : shifted;
      quotBits_d = (quotBits_q << 1) | QW'(qBit);
      fracBits   = (FRAC > 0) ? quotBits_d[FW-1:0] : '0;
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         divisor_q   <= '0;
         dvdShift_q  <= '0;
         prem_q      <= '0;
         intRem_q    <= '0;
         quotBits_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         fraction_q  <= '0;
         remainder_q <= '0;
         divByZero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (bus.divisor != '0) begin
                     divisor_q  <= bus.divisor;
                     dvdShift_q <= bus.dividend;
                     prem_q     <= '0;
                     quotBits_q <= '0;
                     cnt_q      <= '0;
                     state_q    <= ITER;
                  end else begin
                     quotient_q  <= '1;
                     fraction_q  <= {FW{(FRAC > 0)}};
                     remainder_q <= bus.dividend;
                     divByZero_q <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            ITER: begin
               prem_q     <= prem_d;
               dvdShift_q <= {dvdShift_q[WIDTH-2:0], 1'b0};
               quotBits_q <= quotBits_d;
               cnt_q      <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1))
                  intRem_q <= prem_d[WIDTH-1:0];
               // With no fraction bits the last integer step is also the final one.
               if (cnt_q == CW'(QW - 1)) begin
                  quotient_q  <= quotBits_d[QW-1 -: WIDTH];
                  fraction_q  <= fracBits;
                  remainder_q <= (FRAC == 0) ? prem_d[WIDTH-1:0] : intRem_q;
                  divByZero_q <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.fraction    = fraction_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = divByZero_q;
endmodule

// File: tb/tb_divide_seq_frac.sv
// Directed bench for divide_seq_frac: default 8/8 instance plus a 16/4 instance.
// Expected values are hand-computed quotients, fractions and remainders.
module tb_divide_seq_frac;
   logic Clk;
   logic reset_n;

   int vecCount  = 0;
   int missCount = 0;

   divide_seq_frac_if #(.WIDTH(8),  .FRAC(8)) ifA ();
   divide_seq_frac_if #(.WIDTH(16), .FRAC(4)) ifB ();

   divide_seq_frac #(.WIDTH(8), .FRAC(8)) dutA (
      .Clk     (Clk),
      .reset_n (reset_n),
      .bus     (ifA)
   );

   divide_seq_frac #(.WIDTH(16), .FRAC(4)) dutB (
      .Clk     (Clk),
      .reset_n (reset_n),
      .bus     (ifB)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      assert (observed === expected) else begin
         missCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Start is held for exactly one edge; operands are scrambled afterwards since they are don't-care.
   task automatic applyStimulus(input logic [7:0] dvd, input logic [7:0] dvs);
      ifA.start    = 1'b1;
      ifA.dividend = dvd;
      ifA.divisor  = dvs;
      tick();
      ifA.start    = 1'b0;
      ifA.dividend = 8'($urandom);
      ifA.divisor  = 8'($urandom);
   endtask

   task automatic waitDoneA(output int cycles);
      cycles = 0;
      while (ifA.done !== 1'b1 && cycles < 100) begin
         tick();
         cycles++;
      end
   endtask

   task automatic checkResultA(input string tag, input logic [7:0] q, input logic [7:0] f,
                               input logic [7:0] r, input logic dbz);
      checkOutput({tag, ".done"}, 32'(ifA.done), 32'd1);
      checkOutput({tag, ".busy"}, 32'(ifA.busy), 32'd1);
      checkOutput({tag, ".quot"}, 32'(ifA.quotient), 32'(q));
      checkOutput({tag, ".frac"}, 32'(ifA.fraction), 32'(f));
      checkOutput({tag, ".rem"},  32'(ifA.remainder), 32'(r));
      checkOutput({tag, ".dbz"},  32'(ifA.div_by_zero), 32'(dbz));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int cycles;
      int sawDone;

      reset_n      = 1'b0;
      ifA.start    = 1'b0;
      ifA.dividend = '0;
      ifA.divisor  = '0;
      ifB.start    = 1'b0;
      ifB.dividend = '0;
      ifB.divisor  = '0;
      tick();
      tick();
      checkOutput("rst.busy", 32'(ifA.busy), 32'd0);
      checkOutput("rst.done", 32'(ifA.done), 32'd0);
      checkOutput("rst.quot", 32'(ifA.quotient), 32'd0);
      checkOutput("rst.frac", 32'(ifA.fraction), 32'd0);
      checkOutput("rst.rem",  32'(ifA.remainder), 32'd0);
      checkOutput("rst.dbz",  32'(ifA.div_by_zero), 32'd0);
      checkOutput("rstB.busy", 32'(ifB.busy), 32'd0);
      reset_n = 1'b1;
      tick();

      // 7/2 = 3.5, remainder 1; done follows sixteen edges after the start edge.
      applyStimulus(8'd7, 8'd2);
      checkOutput("7/2.busyEarly", 32'(ifA.busy), 32'd1);
      waitDoneA(cycles);
      checkOutput("7/2.latency", 32'(cycles), 32'd16);
      checkResultA("7/2", 8'h03, 8'h80, 8'h01, 1'b0);
      tick();
      checkOutput("7/2.donePulse", 32'(ifA.done), 32'd0);
      checkOutput("7/2.busyIdle",  32'(ifA.busy), 32'd0);
      checkOutput("7/2.hold",      32'(ifA.quotient), 32'h03);

      // 1/3 then 0xFF/1; start raised during the DONE cycle must be ignored there.
      applyStimulus(8'd1, 8'd3);
      waitDoneA(cycles);
      checkOutput("1/3.latency", 32'(cycles), 32'd16);
      checkResultA("1/3", 8'h00, 8'h55, 8'h01, 1'b0);
      ifA.start    = 1'b1;
      ifA.dividend = 8'hFF;
      ifA.divisor  = 8'h01;
      tick();
      checkOutput("b2b.ignoredInDone", 32'(ifA.busy), 32'd0);
      tick();
      ifA.start = 1'b0;
      checkOutput("b2b.accepted", 32'(ifA.busy), 32'd1);
      waitDoneA(cycles);
      checkOutput("FF/1.latency", 32'(cycles), 32'd16);
      checkResultA("FF/1", 8'hFF, 8'h00, 8'h00, 1'b0);
      tick();

      // Divide by zero finishes right after the start edge.
      applyStimulus(8'd5, 8'd0);
      checkResultA("5/0", 8'hFF, 8'hFF, 8'h05, 1'b1);
      tick();
      checkOutput("5/0.donePulse", 32'(ifA.done), 32'd0);
      applyStimulus(8'd8, 8'd4);
      repeat (3) tick();
      checkOutput("8/4.holdQuot", 32'(ifA.quotient), 32'hFF);
      checkOutput("8/4.holdDbz",  32'(ifA.div_by_zero), 32'd1);
      waitDoneA(cycles);
      checkOutput("8/4.latency", 32'(cycles), 32'd13);
      checkResultA("8/4", 8'h02, 8'h00, 8'h00, 1'b0);
      tick();

      // 200/9 with a second start at cycle 5 that must not disturb the run.
      applyStimulus(8'd200, 8'd9);
      repeat (4) tick();
      ifA.start    = 1'b1;
      ifA.dividend = 8'd10;
      ifA.divisor  = 8'd2;
      tick();
      ifA.start = 1'b0;
      waitDoneA(cycles);
      checkOutput("200/9.latency", 32'(cycles), 32'd11);
      checkResultA("200/9", 8'h16, 8'h38, 8'h02, 1'b0);
      tick();
      tick();
      checkOutput("200/9.noRequeue", 32'(ifA.busy), 32'd0);

      // 100/7 aborted by reset mid-run; outputs clear without waiting for a clock.
      applyStimulus(8'd100, 8'd7);
      repeat (5) tick();
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abort.busy", 32'(ifA.busy), 32'd0);
      checkOutput("abort.quot", 32'(ifA.quotient), 32'd0);
      checkOutput("abort.frac", 32'(ifA.fraction), 32'd0);
      checkOutput("abort.rem",  32'(ifA.remainder), 32'd0);
      tick();
      reset_n = 1'b1;
      sawDone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ifA.done === 1'b1) sawDone = 1;
      end
      checkOutput("abort.noDone", 32'(sawDone), 32'd0);
      applyStimulus(8'd100, 8'd7);
      waitDoneA(cycles);
      checkOutput("100/7.latency", 32'(cycles), 32'd16);
      checkResultA("100/7", 8'h0E, 8'h49, 8'h02, 1'b0);
      tick();

      // Wide instance: 1000/7 = 142 remainder 6, fraction 6/7 truncated to four bits = 0xD.
      ifB.start    = 1'b1;
      ifB.dividend = 16'd1000;
      ifB.divisor  = 16'd7;
      tick();
      ifB.start = 1'b0;
      cycles = 0;
      while (ifB.done !== 1'b1 && cycles < 100) begin
         tick();
         cycles++;
      end
      checkOutput("B.latency", 32'(cycles), 32'd20);
      checkOutput("B.quot", 32'(ifB.quotient), 32'd142);
      checkOutput("B.frac", 32'(ifB.fraction), 32'hD);
      checkOutput("B.rem",  32'(ifB.remainder), 32'd6);
      checkOutput("B.dbz",  32'(ifB.div_by_zero), 32'd0);
      tick();
      checkOutput("B.donePulse", 32'(ifB.done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule
